// File: rtl/controle_mem_dados.sv
// controle_mem_dados
// Load/store sequencer between the RV32I core and the word-addressed data
// memory. It takes one request at a time. Loads are lane-extracted with sign
// or zero extension. SB/SH use a read-modify-write over two memory cycles.
// Misaligned, invalid and out-of-range requests are rejected before any
// memory cycle.
//
// Handshake: the core raises req_valido and holds every req_* stable until
// req_pronto. req_pronto is a single-cycle completion pulse, qualified by
// erro_acesso. The request is taken only in OCIOSO, so req_* changes while
// ocupado=1 have no effect. If req_valido is still high in the OCIOSO cycle
// after CONCLUIR, that cycle accepts a new request.

module controle_mem_dados #(
   parameter int unsigned TAMANHO_PALAVRAS = 256
) (
   input  logic        sinal_clk,
   input  logic        sinal_rst_n,
   input  logic        req_valido,
   input  logic        req_escrita,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_endereco,
   input  logic [31:0] req_dado,
   output logic        req_pronto,
   output logic [31:0] resp_dado,
   output logic        erro_acesso,
   output logic        ocupado,
   output logic [31:0] mem_endereco,
   output logic [31:0] mem_dado_saida,
   output logic        mem_habilitar_escrita,
   input  logic [31:0] mem_dado_leitura,
   output logic [2:0]  estado_dbg
);

   // First byte address past the end of data memory
   localparam logic [31:0] LIMITE = 32'(4 * TAMANHO_PALAVRAS);

   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      LEITURA     = 3'd1,
      LEITURA_MOD = 3'd2,
      ESCRITA     = 3'd3,
      CONCLUIR    = 3'd4
   } estado_t;

   estado_t     estado_q, estado_d;
   logic [31:0] end_lat_q, end_lat_d;
   logic [2:0]  f3_lat_q, f3_lat_d;
   logic        esc_lat_q, esc_lat_d;
   logic [31:0] dado_lat_q, dado_lat_d;
   logic        erro_q, erro_d;
   logic [31:0] resp_q, resp_d;
   logic [31:0] mescla_q, mescla_d;

   logic        f3_valido;
   logic        desalinhado;
   logic        fora_faixa;
   logic        req_erro;
   logic [7:0]  byte_sel;
   logic [15:0] meia_sel;
   logic [31:0] valor_carga;
   logic [31:0] palavra_mesclada;

   // Checks the live request. It is only used in OCIOSO, where it is latched.
   always_comb begin
      f3_valido   = 1'b0;
      desalinhado = 1'b0;
      if (req_escrita) begin
         f3_valido = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010);
      end else begin
         f3_valido = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                     (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                     (req_funct3 == 3'b101);
      end
      // The low funct3 bits give the access size for loads and stores alike
      case (req_funct3[1:0])
         2'b01:   desalinhado = req_endereco[0];
         2'b10:   desalinhado = (req_endereco[1:0] != 2'b00);
         default: desalinhado = 1'b0;
      endcase
      fora_faixa = (req_endereco >= LIMITE);
      req_erro   = !f3_valido || desalinhado || fora_faixa;
   end

   // Selects the addressed lane from the memory word and extends it to 32 bits
   always_comb begin
      case (end_lat_q[1:0])
         2'b00:   byte_sel = mem_dado_leitura[7:0];
         2'b01:   byte_sel = mem_dado_leitura[15:8];
         2'b10:   byte_sel = mem_dado_leitura[23:16];
         default: byte_sel = mem_dado_leitura[31:24];
      endcase
      meia_sel = end_lat_q[1] ? mem_dado_leitura[31:16] : mem_dado_leitura[15:0];
      case (f3_lat_q)
         3'b000:  valor_carga = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  valor_carga = {{16{meia_sel[15]}}, meia_sel};
         3'b010:  valor_carga = mem_dado_leitura;
         3'b100:  valor_carga = {24'd0, byte_sel};
         3'b101:  valor_carga = {16'd0, meia_sel};
         default: valor_carga = 32'd0;
      endcase
   end

   // Merges the store data into the current memory word for SB/SH
   always_comb begin
      palavra_mesclada = mem_dado_leitura;
      if (f3_lat_q[0] == 1'b0) begin
         case (end_lat_q[1:0])
            2'b00:   palavra_mesclada[7:0]   = dado_lat_q[7:0];
            2'b01:   palavra_mesclada[15:8]  = dado_lat_q[7:0];
            2'b10:   palavra_mesclada[23:16] = dado_lat_q[7:0];
            default: palavra_mesclada[31:24] = dado_lat_q[7:0];
         endcase
      end else begin
         if (end_lat_q[1]) begin
            palavra_mesclada[31:16] = dado_lat_q[15:0];
         end else begin
            palavra_mesclada[15:0]  = dado_lat_q[15:0];
         end
      end
   end

   // Next-state logic. It latches the request on acceptance and walks the access.
   always_comb begin
      estado_d   = estado_q;
      end_lat_d  = end_lat_q;
      f3_lat_d   = f3_lat_q;
      esc_lat_d  = esc_lat_q;
      dado_lat_d = dado_lat_q;
      erro_d     = erro_q;
      resp_d     = resp_q;
      mescla_d   = mescla_q;
      case (estado_q)
         OCIOSO: begin
            if (req_valido) begin
               end_lat_d  = req_endereco;
               f3_lat_d   = req_funct3;
               esc_lat_d  = req_escrita;
               dado_lat_d = req_dado;
               erro_d     = req_erro;
               resp_d     = 32'd0;
               if (req_erro) begin
                  estado_d = CONCLUIR;
               end else if (!req_escrita) begin
                  estado_d = LEITURA;
               end else if (req_funct3 == 3'b010) begin
                  estado_d = ESCRITA;
               end else begin
                  estado_d = LEITURA_MOD;
               end
            end
         end
         LEITURA: begin
            resp_d   = valor_carga;
            estado_d = CONCLUIR;
         end
         LEITURA_MOD: begin
            mescla_d = palavra_mesclada;
            estado_d = ESCRITA;
         end
         ESCRITA: begin
            estado_d = CONCLUIR;
         end
         CONCLUIR: begin
            estado_d = OCIOSO;
         end
         default: begin
            estado_d = OCIOSO;
         end
      endcase
   end

   // State and latch registers with synchronous active-low reset
   always_ff @(posedge sinal_clk) begin
      if (!sinal_rst_n) begin
         estado_q   <= OCIOSO;
         end_lat_q  <= 32'd0;
         f3_lat_q   <= 3'd0;
         esc_lat_q  <= 1'b0;
         dado_lat_q <= 32'd0;
         erro_q     <= 1'b0;
         resp_q     <= 32'd0;
         mescla_q   <= 32'd0;
      end else begin
         estado_q   <= estado_d;
         end_lat_q  <= end_lat_d;
         f3_lat_q   <= f3_lat_d;
         esc_lat_q  <= esc_lat_d;
         dado_lat_q <= dado_lat_d;
         erro_q     <= erro_d;
         resp_q     <= resp_d;
         mescla_q   <= mescla_d;
      end
   end

   // Outputs are decoded from the registered state. The write enable is also
   // gated by reset, so a reset in ESCRITA suppresses that write.
   assign req_pronto            = (estado_q == CONCLUIR);
   assign erro_acesso           = (estado_q == CONCLUIR) && erro_q;
   assign ocupado               = (estado_q != OCIOSO);
   assign resp_dado             = resp_q;
   assign mem_endereco          = {end_lat_q[31:2], 2'b00};
   assign mem_habilitar_escrita = (estado_q == ESCRITA) && esc_lat_q && sinal_rst_n;
   assign mem_dado_saida        = (estado_q != ESCRITA) ? 32'd0 :
                                  (f3_lat_q == 3'b010) ? dado_lat_q : mescla_q;
   assign estado_dbg            = estado_q;

endmodule

// File: tb/tb_controle_mem_dados.sv
// Bench for controle_mem_dados: directed scenarios from the test plan, then
// randomized requests checked against a byte-level reference memory model.
module tb_controle_mem_dados;

  localparam int PAL = 256;

  logic        clk;
  logic        rst_n;
  logic        req_valido;
  logic        req_escrita;
  logic [2:0]  req_funct3;
  logic [31:0] req_endereco;
  logic [31:0] req_dado;
  logic        req_pronto;
  logic [31:0] resp_dado;
  logic        erro_acesso;
  logic        ocupado;
  logic [31:0] mem_endereco;
  logic [31:0] mem_dado_saida;
  logic        mem_habilitar_escrita;
  logic [31:0] mem_dado_leitura;
  logic [2:0]  estado_dbg;

  logic [31:0] mem [PAL];
  logic [31:0] ref_mem [PAL];

  int n_vec = 0;
  int n_err = 0;

  int          o_lat, o_nwr, o_wrcyc;
  logic        o_err;
  logic [31:0] o_resp;

  controle_mem_dados #(.TAMANHO_PALAVRAS(PAL)) dut (
    .sinal_clk(clk),
    .sinal_rst_n(rst_n),
    .req_valido(req_valido),
    .req_escrita(req_escrita),
    .req_funct3(req_funct3),
    .req_endereco(req_endereco),
    .req_dado(req_dado),
    .req_pronto(req_pronto),
    .resp_dado(resp_dado),
    .erro_acesso(erro_acesso),
    .ocupado(ocupado),
    .mem_endereco(mem_endereco),
    .mem_dado_saida(mem_dado_saida),
    .mem_habilitar_escrita(mem_habilitar_escrita),
    .mem_dado_leitura(mem_dado_leitura),
    .estado_dbg(estado_dbg)
  );

  // clock / memory environment
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_dado_leitura = mem[mem_endereco[9:2]];

  always @(posedge clk) begin
    if (mem_habilitar_escrita) mem[mem_endereco[9:2]] <= mem_dado_saida;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference model: behaviour computed from the access rules
  task automatic model(input logic esc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] dado, output logic e_err, output int e_lat,
                       output logic [31:0] e_resp, output int e_nwr);
    int nbytes;
    int off;
    logic legal;
    logic [31:0] w;
    longint v;
    nbytes = 1 << f3[1:0];
    if (esc) legal = (f3 <= 3'd2);
    else     legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    e_err  = !legal || (addr % nbytes != 0) || (addr >= 32'(4 * PAL));
    e_resp = 32'd0;
    e_nwr  = 0;
    if (e_err) begin
      e_lat = 1;
    end else begin
      off = int'(addr % 4);
      w   = ref_mem[addr / 4];
      if (!esc) begin
        e_lat = 2;
        v = longint'(w >> (8 * off)) % (64'd1 << (8 * nbytes));
        if (!f3[2] && nbytes < 4 && v >= (64'd1 << (8 * nbytes - 1)))
          v = v - (64'd1 << (8 * nbytes));
        e_resp = 32'(v);
      end else begin
        e_lat = (nbytes == 4) ? 2 : 3;
        e_nwr = 1;
        for (int k = 0; k < nbytes; k++) w[8 * (off + k) +: 8] = dado[8 * k +: 8];
        ref_mem[addr / 4] = w;
      end
    end
  endtask

  // driver: drives one request and observes it until req_pronto
  task automatic drive(input logic esc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] dado, input bit scramble);
    req_escrita  = esc;
    req_funct3   = f3;
    req_endereco = addr;
    req_dado     = dado;
    req_valido   = 1'b1;
    o_lat = -1; o_nwr = 0; o_wrcyc = -1; o_err = 1'bx; o_resp = 'x;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_habilitar_escrita) begin
        o_nwr++;
        o_wrcyc = c;
      end
      if (req_pronto) begin
        o_lat  = c;
        o_err  = erro_acesso;
        o_resp = resp_dado;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        req_escrita  = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_endereco = $urandom;
        req_dado     = $urandom;
      end
    end
    @(posedge clk); #1;
    req_valido = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic esc, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] dado, input bit scramble);
    logic        e_err;
    int          e_lat, e_nwr;
    logic [31:0] e_resp;
    logic [7:0]  idx;
    idx = addr[9:2];
    model(esc, f3, addr, dado, e_err, e_lat, e_resp, e_nwr);
    drive(esc, f3, addr, dado, scramble);
    check({tag, " latency"}, 32'(o_lat), 32'(e_lat));
    check({tag, " erro"}, 32'(o_err), 32'(e_err));
    check({tag, " resp"}, o_resp, e_resp);
    check({tag, " writes"}, 32'(o_nwr), 32'(e_nwr));
    if (e_nwr == 1) check({tag, " write cycle"}, 32'(o_wrcyc), 32'(e_lat - 1));
    check({tag, " mem word"}, mem[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] pre;
    logic [31:0] a;
    logic        esc;
    bit          pronto_seen;

    rst_n = 1'b0; req_valido = 1'b0; req_escrita = 1'b0;
    req_funct3 = 3'd0; req_endereco = 32'd0; req_dado = 32'd0;
    for (int i = 0; i < PAL; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end

    // reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst req_pronto", 32'(req_pronto), 32'd0);
    check("rst erro_acesso", 32'(erro_acesso), 32'd0);
    check("rst ocupado", 32'(ocupado), 32'd0);
    check("rst resp_dado", resp_dado, 32'd0);
    check("rst mem_we", 32'(mem_habilitar_escrita), 32'd0);
    check("rst mem_dado_saida", mem_dado_saida, 32'd0);
    check("rst mem_endereco", mem_endereco, 32'd0);
    @(posedge clk); #1;

    // directed plan
    do_req("sw 0x10", 1'b1, 3'b010, 32'h10, 32'h8081_F2F3, 0);
    check("sw 0x10 word", mem[4], 32'h8081_F2F3);
    check("sw 0x10 write cycle", 32'(o_wrcyc), 32'd1);
    do_req("lw 0x10", 1'b0, 3'b010, 32'h10, 32'h0, 0);
    check("lw 0x10 value", o_resp, 32'h8081_F2F3);
    do_req("sw preset", 1'b1, 3'b010, 32'h10, 32'h1122_3344, 0);
    do_req("sb 0x12", 1'b1, 3'b000, 32'h12, 32'h0000_00AB, 0);
    check("sb 0x12 word", mem[4], 32'h11AB_3344);
    do_req("lb 0x12", 1'b0, 3'b000, 32'h12, 32'h0, 0);
    check("lb 0x12 value", o_resp, 32'hFFFF_FFAB);
    do_req("lbu 0x12", 1'b0, 3'b100, 32'h12, 32'h0, 0);
    check("lbu 0x12 value", o_resp, 32'h0000_00AB);
    do_req("lh 0x12", 1'b0, 3'b001, 32'h12, 32'h0, 0);
    check("lh 0x12 value", o_resp, 32'h0000_11AB);
    do_req("sh 0x12", 1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 0);
    check("sh 0x12 word", mem[4], 32'hBEEF_3344);
    check("sh 0x12 latency", 32'(o_lat), 32'd3);
    do_req("err lw 0x11", 1'b0, 3'b010, 32'h11, 32'h0, 0);
    check("err lw 0x11 flag", 32'(o_err), 32'd1);
    do_req("err sh 0x13", 1'b1, 3'b001, 32'h13, 32'h1234, 0);
    check("err sh 0x13 flag", 32'(o_err), 32'd1);
    do_req("err f3 011", 1'b0, 3'b011, 32'h10, 32'h0, 0);
    check("err f3 011 flag", 32'(o_err), 32'd1);
    do_req("err sw 0x400", 1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF, 0);
    check("err sw 0x400 flag", 32'(o_err), 32'd1);
    check("err sw 0x400 latency", 32'(o_lat), 32'd1);

    // reset during the ESCRITA cycle of an SB to 0x20
    pre = mem[8];
    pronto_seen = 0;
    req_escrita = 1'b1; req_funct3 = 3'b000; req_endereco = 32'h20;
    req_dado = 32'h5A; req_valido = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst-escrita ocupado", 32'(ocupado), 32'd1);
    rst_n = 1'b0;
    req_valido = 1'b0;
    @(negedge clk);
    check("rst-escrita we gated", 32'(mem_habilitar_escrita), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (req_pronto) pronto_seen = 1;
    end
    check("rst-escrita no pronto", 32'(pronto_seen), 32'd0);
    check("rst-escrita ocupado after", 32'(ocupado), 32'd0);
    check("rst-escrita word", mem[8], pre);
    @(posedge clk); #1;

    // randomized, back-to-back, with req_* scrambled while busy
    for (int n = 0; n < 300; n++) begin
      esc = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 4 * PAL - 1));
      do_req($sformatf("rnd%0d", n), esc, 3'($urandom_range(0, 7)), a, $urandom, 1);
    end

    // final report
    for (int i = 0; i < PAL; i++) check($sformatf("final word %0d", i), mem[i], ref_mem[i]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/controle_mem_dados.md
# controle_mem_dados

Load/store sequencer between the RV32I core and the word-addressed data memory (`mem_dados`). It accepts one request at a time over a valid/ready handshake. Loads are extracted and sign- or zero-extended by byte lane. SB/SH are performed as a read-modify-write over two memory cycles. Misaligned, invalid and out-of-range accesses are rejected without touching memory.

## Interface
Parameters:
- `TAMANHO_PALAVRAS`, default 256: number of 32-bit words in data memory. Valid byte addresses are `0 .. 4*TAMANHO_PALAVRAS-1`.

Ports:
- `sinal_clk`, input, 1: system clock. All state changes on its rising edge.
- `sinal_rst_n`, input, 1: reset, synchronous, active-low.
- `req_valido`, input, 1: core request valid. Held high with all `req_*` stable until `req_pronto`.
- `req_escrita`, input, 1: 1 = store, 0 = load.
- `req_funct3`, input, 3: RV32I funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_endereco`, input, 32: byte address from the ALU.
- `req_dado`, input, 32: store data (rs2).
- `req_pronto`, output, 1: one-cycle completion pulse.
- `resp_dado`, output, 32: load result. Valid while `req_pronto`=1.
- `erro_acesso`, output, 1: qualifies `req_pronto`. Request rejected.
- `ocupado`, output, 1: high in every state except OCIOSO.
- `mem_endereco`, output, 32: to memory. Always `{end_lat[31:2],2'b00}`.
- `mem_dado_saida`, output, 32: write data to memory.
- `mem_habilitar_escrita`, output, 1: memory write enable.
- `mem_dado_leitura`, input, 32: asynchronous read data from memory.

## Operation
- Request latch: in OCIOSO, when `req_valido`=1, all `req_*` are latched (`end_lat`, `f3_lat`, `esc_lat`, `dado_lat`) and checked.
- Error conditions, all leading to CONCLUIR with the error flag set:
  - funct3 invalid for the direction
  - halfword access with `addr[0]`=1
  - word access with `addr[1:0]`≠0
  - `addr >= 4*TAMANHO_PALAVRAS`
- FSM states: OCIOSO, LEITURA, LEITURA_MOD, ESCRITA, CONCLUIR.
- Transitions from OCIOSO on an accepted, valid request:
  - load → LEITURA
  - SW → ESCRITA
  - SB/SH → LEITURA_MOD
- LEITURA: the extracted value of `mem_dado_leitura` is registered into `resp_dado` → CONCLUIR.
- LEITURA_MOD: merged word is registered → ESCRITA.
  - SB replaces byte lane `addr[1:0]` with `dado_lat[7:0]`.
  - SH replaces lane `addr[1]` with `dado_lat[15:0]`.
- ESCRITA: `mem_habilitar_escrita`=1 and `mem_dado_saida` = merged word (SB/SH) or `dado_lat` (SW) → CONCLUIR.
- CONCLUIR: `req_pronto`=1, with `erro_acesso` as latched → OCIOSO.
- Load extraction is little-endian:
  - LB/LH sign-extend from bit 7/15 of the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- On error: `resp_dado`=0, no memory write, no LEITURA cycle.
- `mem_dado_saida` is 0 outside ESCRITA. `mem_endereco` is driven from `end_lat` in every state.

## Timing
- Reset (`sinal_rst_n`=0 at an edge): state OCIOSO and all outputs 0 (`req_pronto`, `erro_acesso`, `ocupado`, `resp_dado`, `mem_habilitar_escrita`, `mem_dado_saida`, `mem_endereco`). Latched registers cleared.
- `mem_habilitar_escrita` is gated by `sinal_rst_n`. A reset asserted during ESCRITA suppresses that write, and the request is dropped with no `req_pronto`.
- Latency, counting cycle 0 as the OCIOSO acceptance cycle:
  - load and SW: `req_pronto` in cycle 2
  - SB/SH: `req_pronto` in cycle 3
  - error: `req_pronto` in cycle 1
- Back-to-back requests: if `req_valido` is still high in the OCIOSO cycle after CONCLUIR, it is accepted as a new request. The core must drop or change the request in the cycle after `req_pronto`.
- `req_*` changes while `ocupado`=1 are ignored, because only the latched copies are used.
- RMW is atomic with respect to this block: there is no other requester, and memory is only written in ESCRITA.

## Test plan
- Reset: hold `sinal_rst_n`=0 for 2 cycles, release → all outputs 0, `ocupado`=0.
- SW then LW at 0x10, data 0x8081_F2F3:
  - SW: one write pulse in cycle 1.
  - LW: `req_pronto` in cycle 2 with `resp_dado`=0x8081_F2F3.
- SB 0xAB to 0x12 over word 0x1122_3344 → memory word 0x11AB_3344.
- Loads from 0x12: LB → 0xFFFF_FFAB, LBU → 0x0000_00AB, LH → 0x0000_11AB.
- SH 0xBEEF to 0x12 → memory word 0xBEEF_3344, with `req_pronto` in cycle 3.
- Errors, each giving `req_pronto`=1 and `erro_acesso`=1 in cycle 1 with no write:
  - LW at 0x11
  - SH at 0x13
  - funct3=011 load
  - SW at 0x400 with default `TAMANHO_PALAVRAS`
- Reset in the ESCRITA cycle of an SB to 0x20 → memory word at 0x20 unchanged, no `req_pronto`, state OCIOSO.
